main_reg_file: RTL and testbench
================================

MAIN_REG_FILE -- requirements
Module: main_reg_file

Interface
REQ-001 Parameter DATA_W, default 16, register and data width in bits.
REQ-002 Parameter ADRS_W, default 3, register address width; depth is 2**ADRS_W, 8 entries at default.
REQ-003 CLK  input  1  single clock; all state updates on the rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 rdAdrsA  input  ADRS_W  read port A address, driven by the upstream main register address stage.
REQ-006 rdAdrsB  input  ADRS_W  read port B address.
REQ-007 rdDataA  output  DATA_W  registered read data, port A.
REQ-008 rdDataB  output  DATA_W  registered read data, port B.
REQ-009 wrEn  input  1  write-back strobe.
REQ-010 wrAdrs  input  ADRS_W  write-back address.
REQ-011 wrData  input  DATA_W  write-back data.
REQ-012 rsvEn  input  1  reserve strobe; marks wrAdrs-to-be as pending.
REQ-013 rsvAdrs  input  ADRS_W  address to reserve.
REQ-014 stallOut  output  1  combinational hazard/busy flag.
REQ-015 ready  output  1  high when the clear sequence is complete.

Function
REQ-016 The block SHALL hold 2**ADRS_W registers of DATA_W bits, with one pending bit per register.
REQ-017 Register 0 SHALL always read as 0; writes and reserves to address 0 SHALL be ignored, and its pending bit SHALL stay 0.
REQ-018 The FSM SHALL have two states, CLEAR and RUN; Reset SHALL force CLEAR with the clear counter at 0.
REQ-019 In CLEAR, the block SHALL zero one register per cycle, from address 0 upward, and SHALL clear all pending bits on entry.
REQ-020 CLEAR SHALL move to RUN on the cycle after it zeroes the highest address; the sequence takes exactly 2**ADRS_W cycles after Reset deasserts.
REQ-021 ready SHALL be 0 in CLEAR and 1 in RUN.
REQ-022 In CLEAR, wrEn and rsvEn SHALL be ignored.
REQ-023 In RUN, wrEn=1 SHALL write wrData to register wrAdrs at the clock edge and clear that register's pending bit.
REQ-024 In RUN, rsvEn=1 SHALL set the pending bit of rsvAdrs.
REQ-025 When wrEn and rsvEn target the same address in the same cycle, the data SHALL be written and the pending bit SHALL end at 1; reserve wins.
REQ-026 A write to a register whose pending bit is 0 SHALL be accepted normally.
REQ-027 rdDataA and rdDataB SHALL update every cycle with the contents of the addressed register; read latency is 1 cycle.
REQ-028 Same-cycle bypass: if wrEn is accepted and wrAdrs equals a read address other than 0, that port SHALL capture wrData instead of the stored value.
REQ-029 When both ports address the same register, both SHALL return identical data.
REQ-030 stallOut SHALL be 1 when ready=0, or when rdAdrsA or rdAdrsB addresses a pending register.
REQ-031 For REQ-030, a pending register being written in the same cycle SHALL NOT raise stallOut, since the bypass covers it.
REQ-032 The pending bit and the clear counter SHALL NOT wrap or overflow; the counter saturates once the FSM leaves CLEAR.

Reset
REQ-033 While Reset=1, the block SHALL set rdDataA=0, rdDataB=0, ready=0, stallOut=1, all pending bits to 0, and the FSM to CLEAR.
REQ-034 Reset asserted mid-CLEAR or in RUN SHALL restart the full clear sequence on the next cycle; register contents not yet re-cleared are don't-care, but SHALL read as 0 once ready=1.

Verification
REQ-035 Reset for 1 cycle, then idle: ready=0 for exactly 8 cycles, then 1; stallOut=1 until ready=1; all registers read 0x0000.
REQ-036 In RUN, write r3=0xBEEF, then read A=3 the next cycle: rdDataA=0xBEEF one cycle later; write r0=0x1234, then read r0: 0x0000.
REQ-037 rsvEn on r5, then rdAdrsB=5: stallOut=1; wrEn r5=0x00A5 with rdAdrsB=5 in the same cycle: stallOut=0 and rdDataB=0x00A5 next cycle; after that, pending bit of r5 is 0.
REQ-038 wrEn and rsvEn both on r2 with data 0x0F0F: r2=0x0F0F and stallOut=1 for rdAdrsA=2 on the following cycles.
REQ-039 wrEn r7=0xFFFF during CLEAR: ignored, r7 reads 0x0000 after ready=1.
REQ-040 Write r4=0x5555, reserve r6, then Reset for 1 cycle: r4 reads 0x0000 after ready=1, and r6 pending is cleared (stallOut=0 with rdAdrs=6).

Source files
------------

// File: rtl/main_reg_file.sv
// Dual-read, single-write register file with per-register pending (scoreboard) bits.
// After reset it zeroes every entry, one per cycle, before it accepts traffic.
module main_reg_file #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADRS_W = 3
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic [ADRS_W-1:0] rdAdrsA,
  input  logic [ADRS_W-1:0] rdAdrsB,
  output logic [DATA_W-1:0] rdDataA,
  output logic [DATA_W-1:0] rdDataB,
  input  logic              wrEn,
  input  logic [ADRS_W-1:0] wrAdrs,
  input  logic [DATA_W-1:0] wrData,
  input  logic              rsvEn,
  input  logic [ADRS_W-1:0] rsvAdrs,
  output logic              stallOut,
  output logic              ready
);

  localparam int unsigned DEPTH = 1 << ADRS_W;
  localparam logic [ADRS_W-1:0] CNT_MAX = '1;

  typedef enum logic {ST_CLEAR, ST_RUN} state_e;

  state_e              state_q, state_d;
  logic [ADRS_W-1:0]   cnt_q, cnt_d;
  logic [DEPTH-1:0]    pend_q, pend_d;
  logic [DATA_W-1:0]   regs_q [DEPTH];
  logic [DATA_W-1:0]   rd_a_d, rd_b_d;
  logic                run;
  logic                wr_acc;
  logic                rsv_acc;
  logic                hit_a, hit_b;

  assign run     = (state_q == ST_RUN);
  assign wr_acc  = run && wrEn  && (wrAdrs  != '0);
  assign rsv_acc = run && rsvEn && (rsvAdrs != '0);
  assign hit_a   = wr_acc && (wrAdrs == rdAdrsA);
  assign hit_b   = wr_acc && (wrAdrs == rdAdrsB);

  // A pending register being written this cycle is covered by the bypass path.
  assign ready    = run;
  assign stallOut = !run
                 || (pend_q[rdAdrsA] && !hit_a)
                 || (pend_q[rdAdrsB] && !hit_b);

  // Next-state, clear counter, pending bits and read-port selection.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    rd_a_d  = '0;
    rd_b_d  = '0;

    if (!run) begin
      pend_d = '0;
      if (cnt_q == CNT_MAX) state_d = ST_RUN;
      else                  cnt_d   = cnt_q + ADRS_W'(1);
    end else begin
      if (wr_acc)  pend_d[wrAdrs]  = 1'b0;
      if (rsv_acc) pend_d[rsvAdrs] = 1'b1;
    end
    pend_d[0] = 1'b0;

    if (rdAdrsA != '0) rd_a_d = hit_a ? wrData : regs_q[rdAdrsA];
    if (rdAdrsB != '0) rd_b_d = hit_b ? wrData : regs_q[rdAdrsB];
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
      pend_q  <= '0;
      rdDataA <= '0;
      rdDataB <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      rdDataA <= rd_a_d;
      rdDataB <= rd_b_d;
    end
  end

  // Storage: the clear sweep owns the write port until RUN.
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      if (!run)        regs_q[cnt_q]  <= '0;
      else if (wr_acc) regs_q[wrAdrs] <= wrData;
    end
  end

endmodule

// File: tb/tb_main_reg_file.sv
// Self-checking bench for main_reg_file: vector table in RUN plus reset/clear sequences.
module tb_main_reg_file;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 3;

  logic          CLK = 1'b0;
  logic          Reset;
  logic [AW-1:0] rdAdrsA, rdAdrsB, wrAdrs, rsvAdrs;
  logic [DW-1:0] rdDataA, rdDataB, wrData;
  logic          wrEn, rsvEn, stallOut, ready;

  int checks = 0;
  int passes = 0;
  logic [31:0] exp_q[$];

  always #5 CLK = ~CLK;

  main_reg_file #(.DATA_W(DW), .ADRS_W(AW)) dut (
    .CLK(CLK), .Reset(Reset),
    .rdAdrsA(rdAdrsA), .rdAdrsB(rdAdrsB),
    .rdDataA(rdDataA), .rdDataB(rdDataB),
    .wrEn(wrEn), .wrAdrs(wrAdrs), .wrData(wrData),
    .rsvEn(rsvEn), .rsvAdrs(rsvAdrs),
    .stallOut(stallOut), .ready(ready)
  );

  typedef struct {
    logic          wr;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic          rsv;
    logic [AW-1:0] ra;
    logic [AW-1:0] a;
    logic [AW-1:0] b;
    logic [DW-1:0] ea;
    logic [DW-1:0] eb;
    logic          es;
  } vec_t;

  vec_t vecs[16];
  int   nvec;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Drive one cycle; stall is combinational, read data appears after the edge.
  task automatic cyc(input vec_t v, input string nm);
    logic [31:0] e;
    wrEn = v.wr; wrAdrs = v.wa; wrData = v.wd;
    rsvEn = v.rsv; rsvAdrs = v.ra;
    rdAdrsA = v.a; rdAdrsB = v.b;
    exp_q.push_back({v.ea, v.eb});
    #3;
    chk({nm, " stall"}, 32'(stallOut), 32'(v.es));
    @(posedge CLK); #1;
    e = exp_q.pop_front();
    chk({nm, " rdA"}, 32'(rdDataA), 32'(e[31:16]));
    chk({nm, " rdB"}, 32'(rdDataB), 32'(e[15:0]));
  endtask

  // Count edges until ready rises, stall must track !ready throughout.
  task automatic wait_ready(input string nm);
    int n;
    n = 0;
    while (!ready && n < 20) begin
      chk({nm, " stall while clearing"}, 32'(stallOut), 32'd1);
      @(posedge CLK); #1;
      n++;
    end
    chk({nm, " clear cycles"}, 32'(n), 32'd8);
  endtask

  function automatic vec_t mk(input logic wr, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                              input logic rsv, input logic [AW-1:0] ra,
                              input logic [AW-1:0] a, input logic [AW-1:0] b,
                              input logic [DW-1:0] ea, input logic [DW-1:0] eb, input logic es);
    vec_t v;
    v.wr = wr; v.wa = wa; v.wd = wd; v.rsv = rsv; v.ra = ra;
    v.a = a; v.b = b; v.ea = ea; v.eb = eb; v.es = es;
    return v;
  endfunction

  initial begin
    vec_t v;
    Reset = 1'b1; wrEn = 1'b0; rsvEn = 1'b0;
    wrAdrs = '0; wrData = '0; rsvAdrs = '0; rdAdrsA = '0; rdAdrsB = '0;

    vecs[0]  = mk(0, 0, 16'h0000, 0, 0, 7, 1, 16'h0000, 16'h0000, 0);
    vecs[1]  = mk(1, 3, 16'hBEEF, 0, 0, 2, 4, 16'h0000, 16'h0000, 0);
    vecs[2]  = mk(0, 0, 16'h0000, 0, 0, 3, 3, 16'hBEEF, 16'hBEEF, 0);
    vecs[3]  = mk(1, 0, 16'h1234, 0, 0, 0, 3, 16'h0000, 16'hBEEF, 0);
    vecs[4]  = mk(0, 0, 16'h0000, 0, 0, 0, 5, 16'h0000, 16'h0000, 0);
    vecs[5]  = mk(0, 0, 16'h0000, 1, 5, 3, 6, 16'hBEEF, 16'h0000, 0);
    vecs[6]  = mk(0, 0, 16'h0000, 0, 0, 1, 5, 16'h0000, 16'h0000, 1);
    vecs[7]  = mk(1, 5, 16'h00A5, 0, 0, 1, 5, 16'h0000, 16'h00A5, 0);
    vecs[8]  = mk(0, 0, 16'h0000, 0, 0, 5, 5, 16'h00A5, 16'h00A5, 0);
    vecs[9]  = mk(1, 2, 16'h0F0F, 1, 2, 2, 2, 16'h0F0F, 16'h0F0F, 0);
    vecs[10] = mk(0, 0, 16'h0000, 0, 0, 2, 0, 16'h0F0F, 16'h0000, 1);
    vecs[11] = mk(0, 0, 16'h0000, 0, 0, 2, 2, 16'h0F0F, 16'h0F0F, 1);
    vecs[12] = mk(1, 2, 16'h1111, 0, 0, 2, 3, 16'h1111, 16'hBEEF, 0);
    vecs[13] = mk(0, 0, 16'h0000, 0, 0, 1, 2, 16'h0000, 16'h1111, 0);
    vecs[14] = mk(1, 4, 16'h5555, 1, 6, 4, 6, 16'h5555, 16'h0000, 0);
    vecs[15] = mk(0, 0, 16'h0000, 0, 0, 4, 6, 16'h5555, 16'h0000, 1);
    nvec = 16;

    @(posedge CLK); #1;
    @(posedge CLK); #1;
    chk("reset rdA",   32'(rdDataA),  32'd0);
    chk("reset rdB",   32'(rdDataB),  32'd0);
    chk("reset ready", 32'(ready),    32'd0);
    chk("reset stall", 32'(stallOut), 32'd1);

    // Write to r7 during the clear sweep must be dropped.
    Reset = 1'b0;
    wrEn = 1'b1; wrAdrs = 3'd7; wrData = 16'hFFFF;
    wait_ready("initial");
    wrEn = 1'b0;

    for (int i = 0; i < nvec; i++) cyc(vecs[i], $sformatf("vec%0d", i));

    // Mid-RUN reset: r4 data and r6 reservation must both be gone.
    Reset = 1'b1;
    @(posedge CLK); #1;
    chk("rerun ready", 32'(ready),    32'd0);
    chk("rerun stall", 32'(stallOut), 32'd1);
    Reset = 1'b0;
    wait_ready("rerun");
    for (int i = 0; i < 8; i++) begin
      v = mk(0, 0, 16'h0000, 0, 0, AW'(i), AW'(7 - i), 16'h0000, 16'h0000, 0);
      cyc(v, $sformatf("postclr%0d", i));
    end

    chk("queue drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
